// File: rtl/tft_pkg.sv
// Shared constants and FSM state type for the TFT SPI link monitor.
package tft_pkg;
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int unsigned TFT_W = 240;
    localparam int unsigned TFT_H = 320;

    typedef enum logic [2:0] {
        IDLE,
        CASET,
        PASET,
        RAMWR,
        SKIP
    } state_e;
endpackage

// File: rtl/tft_spi_monitor_if.sv
// Write-only 4-wire TFT SPI pins; master drives, monitor observes.
interface tft_spi_monitor_if;
    logic spi_clk;
    logic spi_mosi;
    logic spi_dc;
    logic spi_cs;

    modport master (output spi_clk, spi_mosi, spi_dc, spi_cs);
    modport slave  (input  spi_clk, spi_mosi, spi_dc, spi_cs);
endinterface

// File: rtl/spi_byte_rx.sv
// Synchronises the SPI pins, detects SCLK rising edges and assembles MSB-first bytes.
module spi_byte_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_dc,
    input  logic       spi_cs,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       cmd_valid,
    output logic       frame_err
);
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] dc_sync_q,   dc_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic       sclk_prev_q, sclk_prev_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       byte_dc_q, byte_dc_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       frame_err_q, frame_err_d;

    logic sclk_s, mosi_s, dc_s, cs_s;
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign dc_s   = dc_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q  <= '0;
            mosi_sync_q  <= '0;
            dc_sync_q    <= '0;
            cs_sync_q    <= '1;
            sclk_prev_q  <= 1'b0;
            cnt_q        <= 3'd0;
            shift_q      <= 7'd0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'd0;
            byte_dc_q    <= 1'b0;
            cmd_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            dc_sync_q    <= dc_sync_d;
            cs_sync_q    <= cs_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            byte_dc_q    <= byte_dc_d;
            cmd_valid_q  <= cmd_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // mosi/dc are taken from the same stage as the edge so they stay aligned with it
    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        dc_sync_d    = {dc_sync_q[SYNC_STAGES-2:0], spi_dc};
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
        sclk_prev_d  = sclk_s;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        byte_dc_d    = byte_dc_q;
        cmd_valid_d  = 1'b0;
        frame_err_d  = 1'b0;

        if (cs_s) begin
            cnt_d       = 3'd0;
            frame_err_d = (cnt_q != 3'd0);
        end else if (sclk_s && !sclk_prev_q) begin
            shift_d = {shift_q[5:0], mosi_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                byte_data_d  = {shift_q, mosi_s};
                byte_dc_d    = dc_s;
                cmd_valid_d  = !dc_s;
            end
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign byte_dc    = byte_dc_q;
    assign cmd_valid  = cmd_valid_q;
    assign frame_err  = frame_err_q;
endmodule

// File: rtl/tft_spi_monitor.sv
// TFT SPI bus monitor: decodes CASET/PASET/RAMWR and emits one event per written pixel.
module tft_spi_monitor
    import tft_pkg::*;
#(
    parameter int unsigned COORD_W     = 9,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    tft_spi_monitor_if.slave   spi,
    output logic               byte_valid,
    output logic [7:0]         byte_data,
    output logic               byte_dc,
    output logic               cmd_valid,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_color,
    output logic [COORD_W-1:0] win_xs,
    output logic [COORD_W-1:0] win_xe,
    output logic [COORD_W-1:0] win_ys,
    output logic [COORD_W-1:0] win_ye,
    output logic               proto_err
);
    localparam logic [COORD_W-1:0] XE_RST = COORD_W'(TFT_W - 1);
    localparam logic [COORD_W-1:0] YE_RST = COORD_W'(TFT_H - 1);

    logic       rx_frame_err;

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .spi_clk    (spi.spi_clk),
        .spi_mosi   (spi.spi_mosi),
        .spi_dc     (spi.spi_dc),
        .spi_cs     (spi.spi_cs),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_dc    (byte_dc),
        .cmd_valid  (cmd_valid),
        .frame_err  (rx_frame_err)
    );

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
    logic               hi_flag_q, hi_flag_d;
    logic [7:0]         hi_byte_q, hi_byte_d;
    logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [COORD_W-1:0] win_xs_q, win_xs_d, win_xe_q, win_xe_d;
    logic [COORD_W-1:0] win_ys_q, win_ys_d, win_ye_q, win_ye_d;
    logic               pix_valid_q, pix_valid_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [15:0]        pix_color_q, pix_color_d;
    logic               proto_err_q, proto_err_d;
    logic [COORD_W-1:0] new_start, new_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            p0_q        <= 8'd0;
            p1_q        <= 8'd0;
            p2_q        <= 8'd0;
            hi_flag_q   <= 1'b0;
            hi_byte_q   <= 8'd0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            win_xs_q    <= '0;
            win_xe_q    <= XE_RST;
            win_ys_q    <= '0;
            win_ye_q    <= YE_RST;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_color_q <= 16'd0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            hi_flag_q   <= hi_flag_d;
            hi_byte_q   <= hi_byte_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            win_xs_q    <= win_xs_d;
            win_xe_q    <= win_xe_d;
            win_ys_q    <= win_ys_d;
            win_ye_q    <= win_ye_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_color_q <= pix_color_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        p0_d        = p0_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        hi_flag_d   = hi_flag_q;
        hi_byte_d   = hi_byte_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        win_xs_d    = win_xs_q;
        win_xe_d    = win_xe_q;
        win_ys_d    = win_ys_q;
        win_ye_d    = win_ye_q;
        pix_valid_d = 1'b0;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_color_d = pix_color_q;
        proto_err_d = proto_err_q | rx_frame_err;
        new_start   = COORD_W'({p0_q, p1_q});
        new_end     = COORD_W'({p2_q, byte_data});

        if (byte_valid && !byte_dc) begin
            // any command aborts the running sequence, including a pending colour high byte
            hi_flag_d = 1'b0;
            idx_d     = 2'd0;
            case (byte_data)
                CMD_CASET: state_d = CASET;
                CMD_PASET: state_d = PASET;
                CMD_RAMWR: begin
                    state_d = RAMWR;
                    cur_x_d = win_xs_q;
                    cur_y_d = win_ys_q;
                end
                default:   state_d = SKIP;
            endcase
        end else if (byte_valid) begin
            case (state_q)
                CASET, PASET: begin
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: p0_d = byte_data;
                        2'd1: p1_d = byte_data;
                        2'd2: p2_d = byte_data;
                        default: begin
                            if (state_q == CASET) begin
                                win_xs_d = new_start;
                                win_xe_d = new_end;
                            end else begin
                                win_ys_d = new_start;
                                win_ye_d = new_end;
                            end
                            if (new_start > new_end) proto_err_d = 1'b1;
                            state_d = SKIP;
                        end
                    endcase
                end
                RAMWR: begin
                    if (!hi_flag_q) begin
                        hi_flag_d = 1'b1;
                        hi_byte_d = byte_data;
                    end else begin
                        hi_flag_d   = 1'b0;
                        pix_valid_d = 1'b1;
                        pix_x_d     = cur_x_q;
                        pix_y_d     = cur_y_q;
                        pix_color_d = {hi_byte_q, byte_data};
                        // raster advance with wrap at the window's right and bottom edges
                        if (cur_x_q == win_xe_q) begin
                            cur_x_d = win_xs_q;
                            cur_y_d = (cur_y_q == win_ye_q) ? win_ys_q : cur_y_q + COORD_W'(1);
                        end else begin
                            cur_x_d = cur_x_q + COORD_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_color = pix_color_q;
    assign win_xs    = win_xs_q;
    assign win_xe    = win_xe_q;
    assign win_ys    = win_ys_q;
    assign win_ye    = win_ye_q;
    assign proto_err = proto_err_q;
endmodule

// File: tb/tb_tft_spi_monitor.sv
// Directed bench for tft_spi_monitor: byte table with expected pixels plus corner-case sequences.
module tb_tft_spi_monitor;
    logic       clk;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_dc;
    logic       cmd_valid;
    logic       pix_valid;
    logic [8:0] pix_x, pix_y;
    logic [15:0] pix_color;
    logic [8:0] win_xs, win_xe, win_ys, win_ye;
    logic       proto_err;

    tft_spi_monitor_if spi ();

    tft_spi_monitor #(.COORD_W(9), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi(spi),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
        .cmd_valid(cmd_valid), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_color(pix_color), .win_xs(win_xs), .win_xe(win_xe), .win_ys(win_ys),
        .win_ye(win_ye), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dc;
        logic [7:0]  data;
        logic        exp_pix;
        logic [8:0]  ex;
        logic [8:0]  ey;
        logic [15:0] ecol;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_pass   = 0;

    // event capture
    int          byte_cnt = 0;
    int          cmd_cnt  = 0;
    int          pix_cnt  = 0;
    int          cmd_bad  = 0;
    logic [7:0]  last_byte;
    logic        last_dc;
    logic [8:0]  last_x, last_y;
    logic [15:0] last_col;

    always @(negedge clk) begin
        if (byte_valid) begin
            byte_cnt++;
            last_byte = byte_data;
            last_dc   = byte_dc;
        end
        if (cmd_valid) cmd_cnt++;
        if (cmd_valid != (byte_valid && !byte_dc)) cmd_bad++;
        if (pix_valid) begin
            pix_cnt++;
            last_x   = pix_x;
            last_y   = pix_y;
            last_col = pix_color;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input logic dc, input logic b);
        spi.spi_dc   = dc;
        spi.spi_mosi = b;
        wait_clks(4);
        spi.spi_clk = 1'b1;
        wait_clks(4);
        spi.spi_clk = 1'b0;
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(dc, d[i]);
        wait_clks(8);
    endtask

    task automatic cs_set(input logic v);
        spi.spi_cs = v;
        wait_clks(6);
    endtask

    task automatic add(input logic dc, input logic [7:0] d, input logic p,
                       input logic [8:0] x, input logic [8:0] y, input logic [15:0] c);
        vec_t v;
        v.dc = dc; v.data = d; v.exp_pix = p; v.ex = x; v.ey = y; v.ecol = c;
        vecs.push_back(v);
    endtask

    task automatic cmd(input logic [7:0] d);
        add(1'b0, d, 1'b0, 9'd0, 9'd0, 16'h0);
    endtask

    task automatic dat(input logic [7:0] d);
        add(1'b1, d, 1'b0, 9'd0, 9'd0, 16'h0);
    endtask

    task automatic pix(input logic [7:0] hi, input logic [7:0] lo, input logic [8:0] x, input logic [8:0] y);
        dat(hi);
        add(1'b1, lo, 1'b1, x, y, {hi, lo});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0, c0, p0;
        spi.spi_clk = 1'b0; spi.spi_mosi = 1'b0; spi.spi_dc = 1'b0; spi.spi_cs = 1'b1;
        rst = 1'b0;
        wait_clks(3);

        // reset values
        check("rst byte_valid", 32'(byte_valid), 32'd0);
        check("rst byte_data",  32'(byte_data),  32'd0);
        check("rst cmd_valid",  32'(cmd_valid),  32'd0);
        check("rst pix_valid",  32'(pix_valid),  32'd0);
        check("rst pix_xy",     32'({pix_x, pix_y}), 32'd0);
        check("rst pix_color",  32'(pix_color),  32'd0);
        check("rst win_xs",     32'(win_xs), 32'd0);
        check("rst win_xe",     32'(win_xe), 32'd239);
        check("rst win_ys",     32'(win_ys), 32'd0);
        check("rst win_ye",     32'(win_ye), 32'd319);
        check("rst proto_err",  32'(proto_err), 32'd0);
        rst = 1'b1;
        wait_clks(3);

        // table: unknown command, window setup, pixel stream, 1x1 window wrap
        cmd(8'hA5);
        cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h0C);
        cmd(8'h2B); dat(8'h00); dat(8'h14); dat(8'h00); dat(8'h15);
        cmd(8'h2C);
        pix(8'hF8, 8'h00, 9'd10, 9'd20);
        pix(8'h07, 8'hE0, 9'd11, 9'd20);
        pix(8'h00, 8'h1F, 9'd12, 9'd20);
        pix(8'hFF, 8'hFF, 9'd10, 9'd21);
        pix(8'h00, 8'h00, 9'd11, 9'd21);
        pix(8'h84, 8'h10, 9'd12, 9'd21);
        cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h00);
        cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h00);
        cmd(8'h2C);
        pix(8'h12, 8'h34, 9'd0, 9'd0);
        pix(8'h56, 8'h78, 9'd0, 9'd0);
        pix(8'h9A, 8'hBC, 9'd0, 9'd0);
        pix(8'hDE, 8'hF0, 9'd0, 9'd0);

        cs_set(1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            b0 = byte_cnt; c0 = cmd_cnt; p0 = pix_cnt;
            send_byte(vecs[i].dc, vecs[i].data);
            check($sformatf("v%0d byte count", i), 32'(byte_cnt - b0), 32'd1);
            check($sformatf("v%0d byte_data", i), 32'(last_byte), 32'(vecs[i].data));
            check($sformatf("v%0d byte_dc", i), 32'(last_dc), 32'(vecs[i].dc));
            check($sformatf("v%0d cmd count", i), 32'(cmd_cnt - c0), 32'(!vecs[i].dc));
            check($sformatf("v%0d pix count", i), 32'(pix_cnt - p0), 32'(vecs[i].exp_pix));
            if (vecs[i].exp_pix) begin
                check($sformatf("v%0d pix_x", i), 32'(last_x), 32'(vecs[i].ex));
                check($sformatf("v%0d pix_y", i), 32'(last_y), 32'(vecs[i].ey));
                check($sformatf("v%0d pix_color", i), 32'(last_col), 32'(vecs[i].ecol));
            end
            if (i == 10) begin
                check("win after setup", 32'({win_xs, win_xe, win_ys}), 32'({9'd10, 9'd12, 9'd20}));
                check("win_ye after setup", 32'(win_ye), 32'd21);
            end
        end
        check("proto_err clean", 32'(proto_err), 32'd0);

        // partial byte dropped on cs high, then RAMWR decodes cleanly
        b0 = byte_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'(i % 2));
        cs_set(1'b1);
        check("partial no byte", 32'(byte_cnt - b0), 32'd0);
        check("partial proto_err", 32'(proto_err), 32'd1);
        cs_set(1'b0);
        send_byte(1'b0, 8'h2C);
        check("after partial byte", 32'(last_byte), 32'h2C);
        check("after partial count", 32'(byte_cnt - b0), 32'd1);
        p0 = pix_cnt;
        send_byte(1'b1, 8'hAB);
        send_byte(1'b1, 8'hCD);
        check("after partial pix count", 32'(pix_cnt - p0), 32'd1);
        check("after partial pix", 32'({last_x, last_y, last_col}), 32'({9'd0, 9'd0, 16'hABCD}) );

        // dropped high byte: RAMWR, F8, cmd 00, RAMWR, 07 E0
        cs_set(1'b1);
        rst = 1'b0; wait_clks(2); rst = 1'b1; wait_clks(2);
        check("proto_err cleared", 32'(proto_err), 32'd0);
        cs_set(1'b0);
        send_byte(1'b0, 8'h2A); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h09);
        send_byte(1'b0, 8'h2B); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h07);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h08);
        p0 = pix_cnt;
        send_byte(1'b0, 8'h2C); send_byte(1'b1, 8'hF8);
        send_byte(1'b0, 8'h00);
        send_byte(1'b0, 8'h2C); send_byte(1'b1, 8'h07); send_byte(1'b1, 8'hE0);
        check("abort pix count", 32'(pix_cnt - p0), 32'd1);
        check("abort pix xy", 32'({last_x, last_y}), 32'({9'd5, 9'd7}));
        check("abort pix color", 32'(last_col), 32'h07E0);

        // rst mid-CASET, then a complete CASET
        send_byte(1'b0, 8'h2A); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h03);
        rst = 1'b0;
        wait_clks(2);
        check("midrst win_xs", 32'(win_xs), 32'd0);
        check("midrst win_xe", 32'(win_xe), 32'd239);
        check("midrst outputs", 32'({byte_valid, cmd_valid, pix_valid, proto_err}), 32'd0);
        check("midrst pix", 32'({pix_x, pix_y, pix_color}), 32'd0);
        cs_set(1'b1);
        rst = 1'b1;
        wait_clks(2);
        cs_set(1'b0);
        send_byte(1'b0, 8'h2A); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h1E);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h28);
        check("recaset win_xs", 32'(win_xs), 32'd30);
        check("recaset win_xe", 32'(win_xe), 32'd40);
        check("recaset win_y", 32'({win_ys, win_ye}), 32'({9'd0, 9'd319}));
        check("recaset proto_err", 32'(proto_err), 32'd0);

        // start > end is stored but flagged
        send_byte(1'b0, 8'h2A); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h32);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h28);
        send_byte(1'b1, 8'h01);
        check("inverted win", 32'({win_xs, win_xe}), 32'({9'd50, 9'd40}));
        check("inverted proto_err", 32'(proto_err), 32'd1);
        cs_set(1'b1);

        check("cmd_valid alignment", 32'(cmd_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
